// File: rtl/load_store_unit_pkg.sv
// Shared load/store encodings and request classification for the memory-access stage.
// Funct3 values mirror the LOAD/STORE encodings of the core's instruction set.
package load_store_unit_pkg;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   // Illegal funct3 or misaligned offset; the address range is checked by the caller.
   function automatic logic lsu_bad_access(input logic       write,
                                           input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
      logic illegal;
      logic misaligned;
      if (write) illegal = (funct3 > F3_SW);
      else       illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      // funct3[1:0] encodes the access size for every legal load and store
      case (funct3[1:0])
         2'd1:    misaligned = addr_lo[0];
         2'd2:    misaligned = |addr_lo;
         default: misaligned = 1'b0;
      endcase
      return illegal || misaligned;
   endfunction

endpackage

// File: rtl/load_store_unit_byte_lane.sv
// Little-endian lane logic: extracts and extends a load value and merges a
// sub-word store into the word read back from RAM.
module lsu_byte_lane
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_val,
   output logic [31:0] o_store_word
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      o_load_val = '0;
      case (i_funct3)
         F3_LB:   o_load_val = {{24{w_byte[7]}}, w_byte};
         F3_LH:   o_load_val = {{16{w_half[15]}}, w_half};
         F3_LW:   o_load_val = i_word;
         F3_LBU:  o_load_val = {24'd0, w_byte};
         F3_LHU:  o_load_val = {16'd0, w_half};
         default: o_load_val = '0;
      endcase
   end

   always_comb begin
      o_store_word = i_word;
      case (i_funct3[1:0])
         2'd0: o_store_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
         2'd1: begin
            if (i_addr_lo[1]) o_store_word[31:16] = i_wdata[15:0];
            else              o_store_word[15:0]  = i_wdata[15:0];
         end
         default: o_store_word = i_wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one byte-addressed load/store per transaction against a
// word-addressed synchronous RAM, with read-modify-write for SB/SH.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int RAM_AW = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_error,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      DATA = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t            r_state;
   logic              r_req_ready;
   logic              r_write;
   logic [2:0]        r_funct3;
   logic [1:0]        r_addr_lo;
   logic [31:0]       r_wdata;
   logic              r_resp_valid;
   logic [31:0]       r_resp_rdata;
   logic              r_resp_error;
   logic [RAM_AW-1:0] r_ram_addr;
   logic              r_ram_we;
   logic [31:0]       r_ram_wdata;

   logic        w_range_err;
   logic        w_req_err;
   logic [31:0] w_load_val;
   logic [31:0] w_store_word;

   assign w_range_err = |(req_addr >> (RAM_AW + 2));
   assign w_req_err   = w_range_err || lsu_bad_access(req_write, req_funct3, req_addr[1:0]);

   lsu_byte_lane u_lane (
      .i_funct3     (r_funct3),
      .i_addr_lo    (r_addr_lo),
      .i_word       (ram_rdata),
      .i_wdata      (r_wdata),
      .o_load_val   (w_load_val),
      .o_store_word (w_store_word)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_req_ready  <= 1'b1;
         r_write      <= 1'b0;
         r_funct3     <= '0;
         r_addr_lo    <= '0;
         r_wdata      <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_error <= 1'b0;
         r_ram_addr   <= '0;
         r_ram_we     <= 1'b0;
         r_ram_wdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid && r_req_ready) begin
                  r_write     <= req_write;
                  r_funct3    <= req_funct3;
                  r_addr_lo   <= req_addr[1:0];
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  if (w_req_err) begin
                     // Rejected accesses never reach the RAM
                     r_resp_valid <= 1'b1;
                     r_resp_error <= 1'b1;
                     r_resp_rdata <= '0;
                     r_state      <= RESP;
                  end else begin
                     r_ram_addr <= req_addr[RAM_AW+1:2];
                     if (req_write && (req_funct3 == F3_SW)) begin
                        r_ram_we    <= 1'b1;
                        r_ram_wdata <= req_wdata;
                        r_state     <= WR;
                     end else begin
                        r_state <= RD;
                     end
                  end
               end
            end
            RD: r_state <= DATA;
            DATA: begin
               if (r_write) begin
                  r_ram_wdata <= w_store_word;
                  r_ram_we    <= 1'b1;
                  r_state     <= WR;
               end else begin
                  r_resp_rdata <= w_load_val;
                  r_resp_error <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_state      <= RESP;
               end
            end
            WR: begin
               r_ram_we     <= 1'b0;
               r_resp_valid <= 1'b1;
               r_resp_error <= 1'b0;
               r_resp_rdata <= '0;
               r_state      <= RESP;
            end
            RESP: begin
               r_resp_valid <= 1'b0;
               r_req_ready  <= 1'b1;
               r_state      <= IDLE;
            end
            default: begin
               r_ram_we     <= 1'b0;
               r_resp_valid <= 1'b0;
               r_req_ready  <= 1'b1;
               r_state      <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_error = r_resp_error;
   assign ram_addr   = r_ram_addr;
   assign ram_we     = r_ram_we;
   assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a synchronous RAM, a transaction-level model of the
// expected per-cycle outputs, and directed loads/stores with literal results.
module tb_load_store_unit;

   localparam int RAM_AW = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic [2:0]        req_funct3 = '0;
   logic [31:0]       req_addr = '0;
   logic [31:0]       req_wdata = '0;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_error;
   logic [RAM_AW-1:0] ram_addr;
   logic              ram_we;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   logic [31:0] ram [0:(1<<RAM_AW)-1];
   logic        pre_we = 1'b0;
   int          pre_a = 0;
   logic [31:0] pre_d = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   logic [31:0] model_mem [0:(1<<RAM_AW)-1];
   bit          exp_rv   [int];
   logic [31:0] exp_rd   [int];
   bit          exp_er   [int];
   logic [31:0] exp_wd   [int];
   int          exp_wa   [int];
   bit          exp_busy [int];
   int          last_done = 0;
   int          last_acc = 0;
   bit          got_resp = 1'b0;
   logic [31:0] last_rdata = '0;
   logic        last_err = 1'b0;

   load_store_unit #(.RAM_AW(RAM_AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_error (resp_error),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we)      ram[pre_a]    <= pre_d;
      else if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   // Access size in bytes from the instruction encoding; 0 marks an illegal funct3.
   function automatic int size_of(input bit w, input logic [2:0] f3);
      if (w) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic logic [31:0] mdl_load(input logic [31:0] word, input int sz,
                                            input bit sgn, input int sh);
      logic [63:0] mask;
      logic [63:0] raw;
      mask = (64'd1 << (8 * sz)) - 64'd1;
      raw  = ({32'd0, word} >> sh) & mask;
      if (sgn && sz < 4 && raw[8*sz-1]) raw = raw | ~mask;
      return raw[31:0];
   endfunction

   function automatic logic [31:0] mdl_merge(input logic [31:0] word, input logic [31:0] wd,
                                             input int sz, input int sh);
      logic [63:0] mask;
      logic [63:0] res;
      mask = ((64'd1 << (8 * sz)) - 64'd1) << sh;
      res  = ({32'd0, word} & ~mask) | (({32'd0, wd}) << sh & mask);
      return res[31:0];
   endfunction

   // Record what every cycle after accept cycle n must show for this request.
   task automatic schedule(input int n, input bit w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
      int sz;
      int lat;
      int sh;
      int wi;
      bit err;
      sz  = size_of(w, f3);
      err = (sz == 0) || ((a % sz) != 0) || (a >= 32'(4 << RAM_AW));
      sh  = int'(a[1:0]) * 8;
      wi  = int'(a >> 2) % (1 << RAM_AW);
      if (err) begin
         lat = 1;
         exp_rd[n+lat] = '0;
      end else if (!w) begin
         lat = 3;
         exp_rd[n+lat] = mdl_load(model_mem[wi], sz, (f3 < 3'd4), sh);
      end else if (sz == 4) begin
         lat = 2;
         exp_wd[n+1] = d;
         exp_wa[n+1] = wi;
         exp_rd[n+lat] = '0;
      end else begin
         lat = 4;
         exp_wd[n+3] = mdl_merge(model_mem[wi], d, sz, sh);
         exp_wa[n+3] = wi;
         exp_rd[n+lat] = '0;
      end
      exp_rv[n+lat] = 1'b1;
      exp_er[n+lat] = err;
      for (int i = 1; i <= lat; i++) exp_busy[n+i] = 1'b1;
      last_done = n + lat;
      last_acc  = n;
   endtask

   // Present a request (called #1 after a rising edge) and return once it is accepted.
   task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int tries;
      tries = 0;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = d;
      req_valid  = 1'b1;
      while (req_ready !== 1'b1 && tries < 20) begin
         @(posedge clk);
         #1;
         tries++;
      end
      if (req_ready !== 1'b1) begin
         check("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
      end else begin
         schedule(cyc, w, f3, a, d);
         got_resp = 1'b0;
         @(posedge clk);
         #1;
         req_valid = 1'b0;
      end
   endtask

   task automatic wait_done();
      int tries;
      tries = 0;
      while (cyc <= last_done && tries < 50) begin
         @(posedge clk);
         #1;
         tries++;
      end
   endtask

   task automatic do_op(input string name, input bit w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic lit_err, input logic [31:0] lit_rd);
      issue(w, f3, a, d);
      wait_done();
      check({name, "_seen"}, 32'(got_resp), 32'd1);
      check({name, "_rdata"}, last_rdata, lit_rd);
      check({name, "_error"}, 32'(last_err), 32'(lit_err));
   endtask

   // Per-cycle compare of handshake, RAM port and response against the model.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("req_ready", 32'(req_ready), exp_busy.exists(cyc) ? 32'd0 : 32'd1);
         check("ram_we", 32'(ram_we), 32'(exp_wd.exists(cyc)));
         if (exp_wd.exists(cyc)) begin
            check("ram_addr", 32'(ram_addr), 32'(exp_wa[cyc]));
            check("ram_wdata", ram_wdata, exp_wd[cyc]);
            model_mem[exp_wa[cyc]] = exp_wd[cyc];
         end
         check("resp_valid", 32'(resp_valid), 32'(exp_rv.exists(cyc)));
         if (exp_rv.exists(cyc)) begin
            check("resp_rdata", resp_rdata, exp_rd[cyc]);
            check("resp_error", 32'(resp_error), 32'(exp_er[cyc]));
         end
         if (resp_valid === 1'b1) begin
            got_resp   = 1'b1;
            last_rdata = resp_rdata;
            last_err   = resp_error;
         end
      end
   end

   initial begin
      int n;
      for (int i = 0; i < (1 << RAM_AW); i++) model_mem[i] = '0;
      model_mem[1] = 32'h80FF7F01;
      model_mem[2] = 32'h11223344;
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         pre_we = 1'b1;
         pre_a  = i;
         pre_d  = model_mem[i];
         @(posedge clk);
         #1;
      end
      pre_we = 1'b0;
      rst    = 1'b0;

      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_error", 32'(resp_error), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_ram_wdata", ram_wdata, 32'd0);
      chk_en = 1'b1;

      do_op("lb_5",   1'b0, 3'd0, 32'h5, 32'h0, 1'b0, 32'h0000007F);
      check("lb_5_latency", 32'(last_done - last_acc), 32'd3);
      do_op("lb_7",   1'b0, 3'd0, 32'h7, 32'h0, 1'b0, 32'hFFFFFF80);
      do_op("lbu_7",  1'b0, 3'd4, 32'h7, 32'h0, 1'b0, 32'h00000080);
      do_op("lh_6",   1'b0, 3'd1, 32'h6, 32'h0, 1'b0, 32'hFFFF80FF);
      do_op("lhu_6",  1'b0, 3'd5, 32'h6, 32'h0, 1'b0, 32'h000080FF);
      do_op("lw_4",   1'b0, 3'd2, 32'h4, 32'h0, 1'b0, 32'h80FF7F01);
      do_op("sb_9",   1'b1, 3'd0, 32'h9, 32'hAA, 1'b0, 32'h0);
      check("sb_9_word", ram[2], 32'h1122AA44);
      do_op("sh_a",   1'b1, 3'd1, 32'hA, 32'hBEEF, 1'b0, 32'h0);
      check("sh_a_word", ram[2], 32'hBEEFAA44);
      do_op("sw_c",   1'b1, 3'd2, 32'hC, 32'hDEADBEEF, 1'b0, 32'h0);
      check("sw_c_latency", 32'(last_done - last_acc), 32'd2);
      do_op("lw_c",   1'b0, 3'd2, 32'hC, 32'h0, 1'b0, 32'hDEADBEEF);
      do_op("lw_6",   1'b0, 3'd2, 32'h6, 32'h0, 1'b1, 32'h0);
      do_op("sh_3",   1'b1, 3'd1, 32'h3, 32'h1234, 1'b1, 32'h0);
      do_op("lb_f3",  1'b0, 3'd3, 32'h4, 32'h0, 1'b1, 32'h0);
      do_op("lw_400", 1'b0, 3'd2, 32'h400, 32'h0, 1'b1, 32'h0);
      do_op("sb_bad", 1'b1, 3'd5, 32'h8, 32'h77, 1'b1, 32'h0);
      check("err_words_kept", ram[1], 32'h80FF7F01);

      // Reset two cycles after accepting an SB: the pending write must vanish.
      issue(1'b1, 3'd0, 32'h8, 32'h55);
      n = last_acc;
      @(posedge clk);
      #1;
      rst = 1'b1;
      foreach (exp_busy[k]) if (k > n + 2) exp_busy.delete(k);
      foreach (exp_wd[k])   if (k > n + 2) begin exp_wd.delete(k); exp_wa.delete(k); end
      foreach (exp_rv[k])   if (k > n + 2) exp_rv.delete(k);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_mid_ready", 32'(req_ready), 32'd1);
      check("rst_mid_we", 32'(ram_we), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check("rst_mid_word", ram[2], 32'hBEEFAA44);

      // Second request presented while busy and held until the unit is idle again.
      issue(1'b1, 3'd2, 32'h10, 32'h12345678);
      n = last_acc;
      do_op("held_lw", 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h12345678);
      check("held_accept_cycle", 32'(last_acc - n), 32'd3);

      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b0;
      for (int i = 0; i < 8; i++) check("ram_vs_model", ram[i], model_mem[i]);
      check("final_w3", ram[3], 32'hDEADBEEF);
      check("final_w4", ram[4], 32'h12345678);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage between the core's execute stage and the word-addressed synchronous data RAM.
- Takes one byte-addressed load/store request per transaction: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Loads: selects the byte lane and sign/zero-extends.
- SB/SH: read-modify-write, because the RAM has no byte enables.
- Flags misaligned, illegal-funct3 and out-of-range accesses without touching the RAM.

Parameters:
RAM_AW, 8, RAM word-address width (depth = 2**RAM_AW 32-bit words; byte range 0 .. 4*2**RAM_AW-1)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle, accepts request this cycle
req_write  in  1  1=store, 0=load
req_funct3  in  3  LOAD/STORE funct3 encoding from instructions.vh
req_addr  in  32  byte address
req_wdata  in  32  store data (low byte/half used for SB/SH)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load result (0 for stores/errors)
resp_error  out  1  access rejected, qualified by resp_valid
ram_addr  out  RAM_AW  RAM word address (registered)
ram_we  out  1  RAM write strobe (registered)
ram_wdata  out  32  RAM write data (registered)
ram_rdata  in  32  RAM read data, valid the cycle after ram_addr is presented

Behaviour:
- Reset values:
  - state=IDLE, req_ready=1, resp_valid=0, resp_error=0.
  - resp_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Accept: in IDLE, on req_valid&&req_ready, latch write/funct3/addr/wdata. req_ready=0 in every other state.
- States: IDLE, RD, DATA, WR, RESP.
  - Transitions are listed under the latencies below; accept cycle = N.
- Error check at accept, combinational on the request:
  - Misaligned: halfword needs addr[0]=0; word needs addr[1:0]=0.
  - Illegal funct3: loads 3,6,7; stores >2.
  - Out of range: addr[31:RAM_AW+2]!=0.
  - Any error: IDLE->RESP, resp at N+1 with resp_error=1, resp_rdata=0, no ram_we.
- Load timing: IDLE->RD->DATA->RESP.
  - ram_addr=addr[RAM_AW+1:2] is registered at N.
  - RAM reads in N+1.
  - In DATA (N+2), capture the extracted lane.
  - resp_valid=1 at N+3.
- SW timing: IDLE->WR->RESP.
  - ram_addr and ram_wdata are registered at N; ram_we=1 for exactly cycle N+1.
  - resp_valid at N+2.
- SB/SH timing: IDLE->RD->DATA->WR->RESP.
  - In DATA, merge the new byte/half into ram_rdata; other bytes are preserved.
  - ram_we=1 at N+3; resp_valid at N+4.
- Lane rules, little-endian:
  - Byte k = bits[8k+7:8k], k=addr[1:0].
  - Half at addr[1]=0 -> bits[15:0]; addr[1]=1 -> bits[31:16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- RESP lasts exactly one cycle, then IDLE (req_ready=1 at the next cycle). There is no back-pressure on resp.
- ram_we is asserted only in WR and is 0 in all other states.
- resp_rdata holds its value until the next response.
- rst mid-operation: next cycle is IDLE with ram_we=0 and resp_valid=0, and the pending op is dropped.
  - A RAM write already strobed stays committed.
  - A write not yet strobed never occurs.
- A request arriving while busy is ignored: req_ready=0, and the requester must hold it.

Decomposition:
- Funct3 encodings (LB..LHU, SB/SH/SW) come from the shared instructions.vh. No new constants except the state encoding, which is a localparam in this module.
- One combinational sub-module, lsu_byte_lane:
  - inputs: funct3, addr[1:0], word, wdata
  - outputs: extended load value, merged store word
- The FSM stays in load_store_unit.

Test Plan:
- RAM word 1 = 0x80FF7F01. LB 0x5 -> resp_rdata 0x0000007F at N+3. LB 0x7 -> 0xFFFFFF80. LBU 0x7 -> 0x00000080.
- Same word: LH 0x6 -> 0xFFFF80FF; LHU 0x6 -> 0x000080FF; LW 0x4 -> 0x80FF7F01, resp_error=0.
- Word 2 = 0x11223344:
  - SB 0x9, wdata 0xAA -> ram_we at N+3 with ram_wdata 0x1122AA44, resp at N+4.
  - SH 0xA, wdata 0xBEEF -> word becomes 0xBEEFAA44.
- SW 0xC, wdata 0xDEADBEEF -> ram_we only at N+1, resp at N+2. A following LW 0xC returns 0xDEADBEEF.
- Each of these -> resp_error=1 at N+1, ram_we never asserted, RAM unchanged:
  - LW 0x6
  - SH 0x3
  - LB funct3=3
  - LW 0x400 with RAM_AW=8
- SB issued, rst asserted at N+2 -> state IDLE and ram_we=0 at N+3, no resp_valid, word unchanged. req_valid held high throughout a busy op -> accepted only when req_ready returns to 1.
